// File: rtl/opl3_pkg.sv
// Shared widths, register map constants and register-field update helpers
// for the OPL3 operator parameter sequencer.
package opl3_pkg;

  localparam int BANK_NUM_WIDTH         = 1;
  localparam int OP_NUM_WIDTH           = 5;
  localparam int NUM_BANKS              = 2;
  localparam int NUM_OPERATORS_PER_BANK = 18;
  localparam int NUM_CHANNELS_PER_BANK  = 9;
  localparam int CH_NUM_WIDTH           = 4;

  localparam int REG_ENV_WIDTH   = 4;
  localparam int REG_TL_WIDTH    = 6;
  localparam int REG_KSL_WIDTH   = 2;
  localparam int REG_MULT_WIDTH  = 4;
  localparam int REG_FNUM_WIDTH  = 10;
  localparam int REG_BLOCK_WIDTH = 3;

  localparam logic [7:0] ADDR_NTS     = 8'h08;
  localparam logic [7:0] ADDR_AM_MULT = 8'h20;
  localparam logic [7:0] ADDR_KSL_TL  = 8'h40;
  localparam logic [7:0] ADDR_AR_DR   = 8'h60;
  localparam logic [7:0] ADDR_SL_RR   = 8'h80;
  localparam logic [7:0] ADDR_FNUM_LO = 8'hA0;
  localparam logic [7:0] ADDR_KEY_BLK = 8'hB0;
  localparam logic [7:0] ADDR_DAM     = 8'hBD;

  typedef enum logic [3:0] {
    KIND_NONE,
    KIND_AM_MULT,
    KIND_KSL_TL,
    KIND_AR_DR,
    KIND_SL_RR,
    KIND_FNUM_LO,
    KIND_KEY_BLK,
    KIND_DAM,
    KIND_NTS
  } reg_kind_t;

  typedef struct packed {
    logic                      am;
    logic                      egt;
    logic                      ksr;
    logic [REG_MULT_WIDTH-1:0] mult;
    logic [REG_KSL_WIDTH-1:0]  ksl;
    logic [REG_TL_WIDTH-1:0]   tl;
    logic [REG_ENV_WIDTH-1:0]  ar;
    logic [REG_ENV_WIDTH-1:0]  dr;
    logic [REG_ENV_WIDTH-1:0]  sl;
    logic [REG_ENV_WIDTH-1:0]  rr;
  } op_regs_t;

  typedef struct packed {
    logic                       key_on;
    logic [REG_BLOCK_WIDTH-1:0] block;
    logic [REG_FNUM_WIDTH-1:0]  fnum;
  } ch_regs_t;

  // 2-op channel owning a given operator slot within its bank.
  function automatic logic [CH_NUM_WIDTH-1:0] op_to_ch(input logic [OP_NUM_WIDTH-1:0] op);
    return CH_NUM_WIDTH'((op / 5'd6) * 5'd3 + op % 5'd3);
  endfunction

  function automatic op_regs_t apply_op_write(input op_regs_t cur, input reg_kind_t kind,
                                              input logic [7:0] d);
    op_regs_t r;
    r = cur;
    case (kind)
      KIND_AM_MULT: begin
        r.am   = d[7];
        r.egt  = d[5];
        r.ksr  = d[4];
        r.mult = d[3:0];
      end
      KIND_KSL_TL: begin
        r.ksl = d[7:6];
        r.tl  = d[5:0];
      end
      KIND_AR_DR: begin
        r.ar = d[7:4];
        r.dr = d[3:0];
      end
      KIND_SL_RR: begin
        r.sl = d[7:4];
        r.rr = d[3:0];
      end
      default: ;
    endcase
    return r;
  endfunction

  function automatic ch_regs_t apply_ch_write(input ch_regs_t cur, input reg_kind_t kind,
                                              input logic [7:0] d);
    ch_regs_t r;
    r = cur;
    case (kind)
      KIND_FNUM_LO: r.fnum[7:0] = d;
      KIND_KEY_BLK: begin
        r.key_on    = d[5];
        r.block     = d[4:2];
        r.fnum[9:8] = d[1:0];
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/op_param_sequencer_if.sv
// Host register-write bus into the operator parameter sequencer.
interface op_param_sequencer_if;
  import opl3_pkg::*;

  logic                      wr_en;
  logic [BANK_NUM_WIDTH-1:0] wr_bank;
  logic [7:0]                wr_addr;
  logic [7:0]                wr_data;

  modport master (output wr_en, wr_bank, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_bank, wr_addr, wr_data);
endinterface

// File: rtl/op_reg_decode.sv
// Maps an OPL3 register address to a register kind and operator/channel index.
module op_reg_decode
  import opl3_pkg::*;
(
  input  logic [BANK_NUM_WIDTH-1:0] i_bank,
  input  logic [7:0]                i_addr,
  output reg_kind_t                 o_kind,
  output logic [OP_NUM_WIDTH-1:0]   o_index,
  output logic                      o_valid
);

  logic [4:0]              w_off;
  logic                    w_op_ok;
  logic                    w_ch_ok;
  logic [OP_NUM_WIDTH-1:0] w_op_idx;

  assign w_off    = i_addr[4:0];
  assign w_op_ok  = (w_off[2:0] < 3'd6) && (w_off <= 5'h15);
  assign w_ch_ok  = i_addr[3:0] < CH_NUM_WIDTH'(NUM_CHANNELS_PER_BANK);
  assign w_op_idx = OP_NUM_WIDTH'(w_off[4:3]) * 5'd6 + OP_NUM_WIDTH'(w_off[2:0]);

  always_comb begin
    o_kind  = KIND_NONE;
    o_index = '0;
    if (w_op_ok) begin
      case (i_addr & 8'hE0)
        ADDR_AM_MULT: o_kind = KIND_AM_MULT;
        ADDR_KSL_TL:  o_kind = KIND_KSL_TL;
        ADDR_AR_DR:   o_kind = KIND_AR_DR;
        ADDR_SL_RR:   o_kind = KIND_SL_RR;
        default:      ;
      endcase
      o_index = w_op_idx;
    end
    if (w_ch_ok && (i_addr & 8'hF0) == ADDR_FNUM_LO) begin
      o_kind  = KIND_FNUM_LO;
      o_index = OP_NUM_WIDTH'(i_addr[3:0]);
    end
    if (w_ch_ok && (i_addr & 8'hF0) == ADDR_KEY_BLK) begin
      o_kind  = KIND_KEY_BLK;
      o_index = OP_NUM_WIDTH'(i_addr[3:0]);
    end
    // Globals exist only in bank 0.
    if (i_bank == '0 && i_addr == ADDR_DAM) o_kind = KIND_DAM;
    if (i_bank == '0 && i_addr == ADDR_NTS) o_kind = KIND_NTS;
  end

  assign o_valid = (o_kind != KIND_NONE);

endmodule

// File: rtl/op_param_sequencer.sv
// Holds OPL3 operator/channel registers and, per sample tick, presents the
// 36 operator slots one per cycle with their registered parameters.
module op_param_sequencer
  import opl3_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_tick,
  op_param_sequencer_if.slave        host,
  output logic                       sample_clk_en,
  output logic [BANK_NUM_WIDTH-1:0]  bank_num,
  output logic [OP_NUM_WIDTH-1:0]    op_num,
  output logic [REG_ENV_WIDTH-1:0]   ar,
  output logic [REG_ENV_WIDTH-1:0]   dr,
  output logic [REG_ENV_WIDTH-1:0]   sl,
  output logic [REG_ENV_WIDTH-1:0]   rr,
  output logic [REG_TL_WIDTH-1:0]    tl,
  output logic [REG_KSL_WIDTH-1:0]   ksl,
  output logic [REG_MULT_WIDTH-1:0]  mult,
  output logic [REG_FNUM_WIDTH-1:0]  fnum,
  output logic [REG_BLOCK_WIDTH-1:0] block,
  output logic                       ksr,
  output logic                       egt,
  output logic                       am,
  output logic                       dam,
  output logic                       nts,
  output logic                       key_on,
  output logic                       busy,
  output logic                       overrun
);

  typedef enum logic {ST_IDLE, ST_SWEEP} seq_state_t;

  localparam logic [OP_NUM_WIDTH-1:0]   LAST_OP   = OP_NUM_WIDTH'(NUM_OPERATORS_PER_BANK - 1);
  localparam logic [BANK_NUM_WIDTH-1:0] LAST_BANK = BANK_NUM_WIDTH'(NUM_BANKS - 1);

  op_regs_t   r_op_regs [NUM_BANKS][NUM_OPERATORS_PER_BANK];
  ch_regs_t   r_ch_regs [NUM_BANKS][NUM_CHANNELS_PER_BANK];
  logic       r_dam, r_nts, r_overrun;
  seq_state_t r_state, w_state_next;

  reg_kind_t                 w_kind;
  logic [OP_NUM_WIDTH-1:0]   w_index;
  logic                      w_valid, w_wr, w_load;
  logic [BANK_NUM_WIDTH-1:0] w_nb;
  logic [OP_NUM_WIDTH-1:0]   w_no;
  logic [CH_NUM_WIDTH-1:0]   w_ch_idx;
  op_regs_t                  w_op_fwd;
  ch_regs_t                  w_ch_fwd;
  logic                      w_dam_fwd, w_nts_fwd;

  op_reg_decode u_decode (
    .i_bank  (host.wr_bank),
    .i_addr  (host.wr_addr),
    .o_kind  (w_kind),
    .o_index (w_index),
    .o_valid (w_valid)
  );

  assign w_wr = host.wr_en & w_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op_regs <= '{default: '0};
      r_ch_regs <= '{default: '0};
      r_dam     <= 1'b0;
      r_nts     <= 1'b0;
    end else if (w_wr) begin
      case (w_kind)
        KIND_AM_MULT, KIND_KSL_TL, KIND_AR_DR, KIND_SL_RR:
          r_op_regs[host.wr_bank][w_index] <=
            apply_op_write(r_op_regs[host.wr_bank][w_index], w_kind, host.wr_data);
        KIND_FNUM_LO, KIND_KEY_BLK:
          r_ch_regs[host.wr_bank][w_index[CH_NUM_WIDTH-1:0]] <=
            apply_ch_write(r_ch_regs[host.wr_bank][w_index[CH_NUM_WIDTH-1:0]], w_kind, host.wr_data);
        KIND_DAM: r_dam <= host.wr_data[7];
        KIND_NTS: r_nts <= host.wr_data[6];
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_nb         = bank_num;
    w_no         = op_num;
    case (r_state)
      ST_IDLE: begin
        if (sample_tick) begin
          w_load       = 1'b1;
          w_nb         = '0;
          w_no         = '0;
          w_state_next = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        if (bank_num == LAST_BANK && op_num == LAST_OP) begin
          w_state_next = ST_IDLE;
        end else begin
          w_load = 1'b1;
          if (op_num == LAST_OP) begin
            w_nb = bank_num + 1'b1;
            w_no = '0;
          end else begin
            w_no = op_num + 1'b1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // A host write landing in the same cycle a slot is loaded is forwarded,
  // so the slot sees register contents as of the end of that cycle.
  always_comb begin
    w_ch_idx  = op_to_ch(w_no);
    w_op_fwd  = r_op_regs[w_nb][w_no];
    w_ch_fwd  = r_ch_regs[w_nb][w_ch_idx];
    w_dam_fwd = r_dam;
    w_nts_fwd = r_nts;
    if (w_wr && host.wr_bank == w_nb) begin
      if (w_index == w_no)
        w_op_fwd = apply_op_write(w_op_fwd, w_kind, host.wr_data);
      if (w_index == OP_NUM_WIDTH'(w_ch_idx))
        w_ch_fwd = apply_ch_write(w_ch_fwd, w_kind, host.wr_data);
    end
    if (w_wr && w_kind == KIND_DAM) w_dam_fwd = host.wr_data[7];
    if (w_wr && w_kind == KIND_NTS) w_nts_fwd = host.wr_data[6];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_clk_en <= 1'b0;
      r_overrun     <= 1'b0;
      bank_num      <= '0;
      op_num        <= '0;
      {ar, dr, sl, rr, tl, ksl, mult, ksr, egt, am} <= '0;
      {fnum, block, key_on, dam, nts}              <= '0;
    end else begin
      sample_clk_en <= w_load;
      if (sample_tick && r_state == ST_SWEEP) r_overrun <= 1'b1;
      if (w_load) begin
        bank_num <= w_nb;
        op_num   <= w_no;
        ar       <= w_op_fwd.ar;
        dr       <= w_op_fwd.dr;
        sl       <= w_op_fwd.sl;
        rr       <= w_op_fwd.rr;
        tl       <= w_op_fwd.tl;
        ksl      <= w_op_fwd.ksl;
        mult     <= w_op_fwd.mult;
        ksr      <= w_op_fwd.ksr;
        egt      <= w_op_fwd.egt;
        am       <= w_op_fwd.am;
        fnum     <= w_ch_fwd.fnum;
        block    <= w_ch_fwd.block;
        key_on   <= w_ch_fwd.key_on;
        dam      <= w_dam_fwd;
        nts      <= w_nts_fwd;
      end
    end
  end

  assign busy    = (r_state == ST_SWEEP);
  assign overrun = r_overrun;

endmodule

// File: tb/tb_op_param_sequencer.sv
// Directed self-checking bench for op_param_sequencer: slot timing, register
// decode, channel mapping, write forwarding, overrun and reset behaviour.
module tb_op_param_sequencer;
  import opl3_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sample_tick = 1'b0;

  op_param_sequencer_if host ();

  logic                       sample_clk_en;
  logic [BANK_NUM_WIDTH-1:0]  bank_num;
  logic [OP_NUM_WIDTH-1:0]    op_num;
  logic [REG_ENV_WIDTH-1:0]   ar, dr, sl, rr;
  logic [REG_TL_WIDTH-1:0]    tl;
  logic [REG_KSL_WIDTH-1:0]   ksl;
  logic [REG_MULT_WIDTH-1:0]  mult;
  logic [REG_FNUM_WIDTH-1:0]  fnum;
  logic [REG_BLOCK_WIDTH-1:0] block;
  logic                       ksr, egt, am, dam, nts, key_on, busy, overrun;

  op_param_sequencer dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .host(host.slave),
    .sample_clk_en(sample_clk_en), .bank_num(bank_num), .op_num(op_num),
    .ar(ar), .dr(dr), .sl(sl), .rr(rr), .tl(tl), .ksl(ksl), .mult(mult),
    .fnum(fnum), .block(block), .ksr(ksr), .egt(egt), .am(am), .dam(dam),
    .nts(nts), .key_on(key_on), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] ar, dr, sl, rr;
    logic [5:0] tl;
    logic [1:0] ksl;
    logic [3:0] mult;
    logic [9:0] fnum;
    logic [2:0] block;
    logic       ksr, egt, am, dam, nts, key_on;
  } slot_t;

  slot_t exp_slot [36];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic slot_t observed();
    slot_t s;
    s.ar = ar; s.dr = dr; s.sl = sl; s.rr = rr; s.tl = tl; s.ksl = ksl;
    s.mult = mult; s.fnum = fnum; s.block = block; s.ksr = ksr; s.egt = egt;
    s.am = am; s.dam = dam; s.nts = nts; s.key_on = key_on;
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 36; i++) exp_slot[i] = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sample_tick = 1'b0;
    host.wr_en = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wr(input logic b, input logic [7:0] a, input logic [7:0] d);
    host.wr_en = 1'b1; host.wr_bank = b; host.wr_addr = a; host.wr_data = d;
    step();
    host.wr_en = 1'b0;
  endtask

  // Tick at relative cycle 0; optional second tick and one host write at
  // given relative cycles; checks all 36 slots and the idle cycle after.
  task automatic sweep(input string tag, input int extra, input int wr_at,
                       input logic wb, input logic [7:0] wa, input logic [7:0] wd);
    for (int s = 0; s <= 36; s++) begin
      sample_tick  = (s == 0) || (s == extra);
      host.wr_en   = (s == wr_at);
      host.wr_bank = wb; host.wr_addr = wa; host.wr_data = wd;
      step();
      if (s < 36) begin
        chk($sformatf("%s slot%0d ctl", tag, s), {sample_clk_en, busy, bank_num, op_num},
            {1'b1, 1'b1, 1'(s / 18), 5'(s % 18)});
        chk($sformatf("%s slot%0d params", tag, s), observed(), exp_slot[s]);
      end else begin
        chk($sformatf("%s idle_after", tag), {sample_clk_en, busy, bank_num, op_num},
            {1'b0, 1'b0, 1'b1, 5'd17});
      end
    end
    sample_tick = 1'b0;
    host.wr_en  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with write and tick asserted: neither may have any effect.
    host.wr_en = 1'b1; host.wr_bank = 1'b0; host.wr_addr = 8'h40; host.wr_data = 8'h3F;
    sample_tick = 1'b1;
    step(); step(); step();
    chk("reset ctl", {sample_clk_en, busy, overrun, bank_num, op_num}, '0);
    chk("reset params", observed(), '0);
    reset = 1'b0; sample_tick = 1'b0; host.wr_en = 1'b0;
    step();
    chk("post_reset idle", {sample_clk_en, busy, overrun}, '0);
    clear_exp();
    sweep("zero", -1, -1, 1'b0, 8'h00, 8'h00);
    chk("zero overrun", overrun, 1'b0);

    // Envelope registers, bank 1 op11 and op17; outputs hold after the sweep.
    do_reset();
    wr(1'b1, 8'h6D, 8'hA5);
    wr(1'b1, 8'h8D, 8'h3C);
    wr(1'b1, 8'h55, 8'h8A);
    clear_exp();
    exp_slot[29].ar = 4'hA; exp_slot[29].dr = 4'h5;
    exp_slot[29].sl = 4'h3; exp_slot[29].rr = 4'hC;
    exp_slot[35].ksl = 2'd2; exp_slot[35].tl = 6'h0A;
    sweep("env", -1, -1, 1'b0, 8'h00, 8'h00);
    step();
    chk("hold params", observed(), exp_slot[35]);
    chk("hold ctl", {sample_clk_en, bank_num, op_num}, {1'b0, 1'b1, 5'd17});

    // Channel 4 drives ops 7 and 10; AM/MULT fields on two operators.
    do_reset();
    wr(1'b0, 8'hA4, 8'h55);
    wr(1'b0, 8'hB4, 8'h2E);
    wr(1'b0, 8'h21, 8'hF7);
    wr(1'b1, 8'h33, 8'h2A);
    clear_exp();
    exp_slot[7].key_on = 1'b1; exp_slot[7].block = 3'd3; exp_slot[7].fnum = 10'h255;
    exp_slot[10].key_on = 1'b1; exp_slot[10].block = 3'd3; exp_slot[10].fnum = 10'h255;
    exp_slot[1].am = 1'b1; exp_slot[1].egt = 1'b1; exp_slot[1].ksr = 1'b1; exp_slot[1].mult = 4'h7;
    exp_slot[33].egt = 1'b1; exp_slot[33].mult = 4'hA;
    sweep("chan", -1, -1, 1'b0, 8'h00, 8'h00);

    // Decode holes, out-of-range channels and bank-1 globals are ignored.
    do_reset();
    wr(1'b0, 8'h46, 8'hFF);
    wr(1'b0, 8'h26, 8'hFF);
    wr(1'b0, 8'h2E, 8'hFF);
    wr(1'b0, 8'h97, 8'hFF);
    wr(1'b0, 8'hA9, 8'hFF);
    wr(1'b0, 8'hB9, 8'hFF);
    wr(1'b1, 8'hBD, 8'h80);
    wr(1'b1, 8'h08, 8'h40);
    clear_exp();
    sweep("holes", -1, -1, 1'b0, 8'h00, 8'h00);
    wr(1'b0, 8'hBD, 8'h80);
    wr(1'b0, 8'h08, 8'h40);
    for (int i = 0; i < 36; i++) begin
      exp_slot[i].dam = 1'b1;
      exp_slot[i].nts = 1'b1;
    end
    sweep("globals", -1, -1, 1'b0, 8'h00, 8'h00);

    // Overrun: second tick mid-sweep, then at the last slot cycle.
    do_reset();
    clear_exp();
    sweep("ovr10", 10, -1, 1'b0, 8'h00, 8'h00);
    chk("ovr10 flag", overrun, 1'b1);
    sweep("ovr_sticky", -1, -1, 1'b0, 8'h00, 8'h00);
    chk("ovr sticky", overrun, 1'b1);
    do_reset();
    chk("ovr cleared", overrun, 1'b0);
    sweep("ovr36", 36, -1, 1'b0, 8'h00, 8'h00);
    step();
    chk("ovr36 no_restart", {sample_clk_en, busy, overrun}, {1'b0, 1'b0, 1'b1});

    // Write forwarding relative to the slot load cycle.
    do_reset();
    clear_exp();
    exp_slot[0].tl = 6'h3F;
    sweep("fwd_t0", -1, 0, 1'b0, 8'h40, 8'h3F);
    do_reset();
    clear_exp();
    sweep("fwd_t1", -1, 1, 1'b0, 8'h40, 8'h3F);
    exp_slot[0].tl = 6'h3F;
    sweep("fwd_next", -1, -1, 1'b0, 8'h00, 8'h00);
    do_reset();
    clear_exp();
    exp_slot[18].tl = 6'h3F;
    sweep("fwd_bank1", -1, 0, 1'b1, 8'h40, 8'h3F);
    exp_slot[18].sl = 4'h4; exp_slot[18].rr = 4'h7;
    sweep("mid_write", -1, 5, 1'b1, 8'h80, 8'h47);

    // Reset mid-sweep aborts; next sweep restarts at bank0 op0.
    do_reset();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step(); step(); step(); step();
    chk("mid pre_reset", {sample_clk_en, busy, bank_num, op_num}, {1'b1, 1'b1, 1'b0, 5'd4});
    reset = 1'b1;
    step();
    chk("mid reset", {sample_clk_en, busy, bank_num, op_num}, '0);
    reset = 1'b0;
    step();
    chk("mid released", {sample_clk_en, busy}, '0);
    clear_exp();
    sweep("restart", -1, -1, 1'b0, 8'h00, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
